alu_req_scheduler: RTL and testbench
====================================

Name: alu_req_scheduler

Overview:
- Shares one ALU datapath between two requesters (Req0, Req1) using round-robin arbitration.
- Each accepted command is issued to the ALU: drives ALU_FUN, operands and ALU_EN for a class-dependent number of cycles.
- Captures the ALU result and returns it to the winner over a valid/ready response channel.
- ALU_FUN[3:2] selects the unit class consumed by the ALU's unit decoder: 00 arith, 01 logic, 10 cmp, 11 shift. ALU_FUN[1:0] is the sub-op, passed through untouched.

Parameters:
- DATA_W, 16, operand and result width.
- ARITH_LAT, 2, ALU_EN cycles for class 00.
- LOGIC_LAT, 1, ALU_EN cycles for class 01.
- CMP_LAT, 1, ALU_EN cycles for class 10.
- SHIFT_LAT, 3, ALU_EN cycles for class 11.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- Req0_Valid  in  1  requester 0 command valid.
- Req0_Fun  in  4  requester 0 ALU function.
- Req0_A  in  DATA_W  requester 0 operand A.
- Req0_B  in  DATA_W  requester 0 operand B.
- Req0_Ready  out  1  requester 0 accept (combinational).
- Req1_Valid, Req1_Fun, Req1_A, Req1_B, Req1_Ready: same as Req0, for requester 1.
- Rsp_Valid  out  1  response valid.
- Rsp_Id  out  1  requester that owns the response.
- Rsp_Data  out  DATA_W  captured ALU result.
- Rsp_Ready  in  1  response consumer ready.
- ALU_FUN  out  4  function to ALU.
- ALU_A  out  DATA_W  operand A to ALU.
- ALU_B  out  DATA_W  operand B to ALU.
- ALU_EN  out  1  ALU enable.
- ALU_OUT  in  DATA_W  ALU result.
- Busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (RST low, async):
  - State = IDLE; last_grant = 1, so Req0 wins the first contention.
  - All outputs 0: Rsp_Valid, Rsp_Id, Rsp_Data, ALU_FUN, ALU_A, ALU_B, ALU_EN, Busy, Req0_Ready, Req1_Ready.
- States: IDLE, EXEC, RESP.
- IDLE arbitration:
  - Only Req0_Valid high: Req0_Ready = 1.
  - Only Req1_Valid high: Req1_Ready = 1.
  - Both high: grant the requester other than last_grant.
  - Ready is 0 in EXEC and RESP.
- Handshake:
  - Accept occurs on the edge where Valid & Ready are both high.
  - On accept, latch Fun, A, B and Id; set last_grant = Id; load cnt with the latency for Fun[3:2]; go to EXEC.
- Requester rules:
  - A requester may drop Valid before it is granted; this is not an error and no transaction occurs.
  - The values sampled are those present on the accept edge.
- EXEC:
  - ALU_EN = 1; ALU_FUN, ALU_A, ALU_B driven from the latched registers.
  - cnt decrements each cycle.
  - When cnt == 1: capture ALU_OUT into Rsp_Data, set Rsp_Id, go to RESP.
  - ALU_EN is therefore high for exactly LAT consecutive cycles.
- Latency:
  - Accept at edge T.
  - ALU_EN high for cycles T+1 .. T+LAT.
  - Rsp_Valid high from cycle T+LAT+1.
- Latency parameter of 0: treated as 1.
- Counter width: 3 bits; latencies above 7 are unsupported.
- RESP:
  - Rsp_Valid = 1; ALU_EN = 0.
  - Rsp_Data and Rsp_Id held stable until Rsp_Valid & Rsp_Ready.
  - On that handshake edge: Rsp_Valid drops next cycle; go to IDLE.
  - A new accept is possible in the first IDLE cycle.
  - Minimum initiation interval: LAT + 2 cycles.
- Outside EXEC: ALU_FUN, ALU_A, ALU_B hold their last latched values; ALU_EN = 0.
- Reset mid-operation:
  - An EXEC or RESP in progress is abandoned; no response is produced.
  - All outputs return to reset values immediately, without waiting for CLK.
- Rsp_Ready high while Rsp_Valid is low: ignored.

Test Plan:
1. Reset: hold RST low with random inputs -> all outputs 0; after release, first contention goes to Req0.
2. Single arith op: Req0 Fun=4'b0000, A=5, B=3; ALU model returns A+B -> Req0_Ready high on cycle 0; ALU_EN high cycles 1–2; Rsp_Valid on cycle 3 with Rsp_Data=8, Rsp_Id=0.
3. Contention: Req0 and Req1 both valid continuously, each with Fun=4'b0100 and Rsp_Ready=1 -> accepts alternate 0,1,0,1; each op takes 3 cycles (LOGIC_LAT+2).
4. Back-pressure: Rsp_Ready low for 5 cycles in RESP -> Rsp_Valid, Rsp_Data, Rsp_Id stable; both Ready low; no ALU_EN; accept resumes the cycle after the handshake.
5. Shift class: Req1 Fun=4'b1101 -> ALU_EN high exactly 3 cycles; Rsp_Data equals ALU_OUT sampled in the 3rd cycle.
6. Reset mid-EXEC: drop RST during ALU_EN -> outputs 0 with no clock edge; no Rsp_Valid afterwards; both valid after release -> Req0 wins.

Source files
------------

// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: shares one ALU between two requesters with round-robin
// arbitration, class-dependent issue length and a valid/ready response port.
module alu_req_scheduler #(
    parameter int DATA_W    = 16,
    parameter int ARITH_LAT = 2,
    parameter int LOGIC_LAT = 1,
    parameter int CMP_LAT   = 1,
    parameter int SHIFT_LAT = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req0_Valid,
    input  logic [3:0]        Req0_Fun,
    input  logic [DATA_W-1:0] Req0_A,
    input  logic [DATA_W-1:0] Req0_B,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [3:0]        Req1_Fun,
    input  logic [DATA_W-1:0] Req1_A,
    input  logic [DATA_W-1:0] Req1_B,
    output logic              Req1_Ready,
    output logic              Rsp_Valid,
    output logic              Rsp_Id,
    output logic [DATA_W-1:0] Rsp_Data,
    input  logic              Rsp_Ready,
    output logic [3:0]        ALU_FUN,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic              ALU_EN,
    input  logic [DATA_W-1:0] ALU_OUT,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // A zero latency still needs one enable cycle to sample the ALU.
    localparam logic [2:0] ARITH_CNT = (ARITH_LAT < 1) ? 3'd1 : 3'(ARITH_LAT);
    localparam logic [2:0] LOGIC_CNT = (LOGIC_LAT < 1) ? 3'd1 : 3'(LOGIC_LAT);
    localparam logic [2:0] CMP_CNT   = (CMP_LAT < 1)   ? 3'd1 : 3'(CMP_LAT);
    localparam logic [2:0] SHIFT_CNT = (SHIFT_LAT < 1) ? 3'd1 : 3'(SHIFT_LAT);

    state_t            state_q;
    state_t            state_d;
    logic              last_q;
    logic              id_q;
    logic [2:0]        cnt_q;
    logic [3:0]        fun_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_id_q;

    logic              pick0;
    logic              pick1;
    logic              acc_any;
    logic              acc_id;
    logic [3:0]        acc_fun;
    logic [DATA_W-1:0] acc_a;
    logic [DATA_W-1:0] acc_b;
    logic              last_cycle;

    function automatic logic [2:0] lat_of(input logic [1:0] cls);
        logic [2:0] l;
        unique case (cls)
            2'b00:   l = ARITH_CNT;
            2'b01:   l = LOGIC_CNT;
            2'b10:   l = CMP_CNT;
            default: l = SHIFT_CNT;
        endcase
        return l;
    endfunction

    // Both valid: the requester that did not win last time goes first.
    always_comb begin
        pick0   = Req0_Valid & (~Req1_Valid | last_q);
        pick1   = Req1_Valid & (~Req0_Valid | ~last_q);
        acc_any = RST & (state_q == IDLE) & (pick0 | pick1);
        acc_id  = pick1;
        acc_fun = pick1 ? Req1_Fun : Req0_Fun;
        acc_a   = pick1 ? Req1_A : Req0_A;
        acc_b   = pick1 ? Req1_B : Req0_B;
    end

    assign last_cycle = (cnt_q <= 3'd1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        Req0_Ready = 1'b0;
        Req1_Ready = 1'b0;
        ALU_EN     = 1'b0;
        Rsp_Valid  = 1'b0;
        Busy       = 1'b1;
        unique case (state_q)
            IDLE: begin
                Busy       = 1'b0;
                Req0_Ready = RST & pick0;
                Req1_Ready = RST & pick1;
                if (acc_any) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                ALU_EN = 1'b1;
                if (last_cycle) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                Rsp_Valid = 1'b1;
                if (Rsp_Ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                Busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_q     <= 1'b1;
            id_q       <= 1'b0;
            cnt_q      <= 3'd0;
            fun_q      <= 4'd0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else begin
            if (acc_any) begin
                last_q <= acc_id;
                id_q   <= acc_id;
                fun_q  <= acc_fun;
                a_q    <= acc_a;
                b_q    <= acc_b;
                cnt_q  <= lat_of(acc_fun[3:2]);
            end
            if (state_q == EXEC) begin
                cnt_q <= cnt_q - 3'd1;
                if (last_cycle) begin
                    rsp_data_q <= ALU_OUT;
                    rsp_id_q   <= id_q;
                end
            end
        end
    end

    assign ALU_FUN  = fun_q;
    assign ALU_A    = a_q;
    assign ALU_B    = b_q;
    assign Rsp_Data = rsp_data_q;
    assign Rsp_Id   = rsp_id_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Randomised scoreboard bench for alu_req_scheduler against a
// transaction-level model of arbitration, issue length and responses.
module tb_alu_req_scheduler;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Req0_Valid = 1'b0;
    logic [3:0]    Req0_Fun = '0;
    logic [DW-1:0] Req0_A = '0;
    logic [DW-1:0] Req0_B = '0;
    logic          Req0_Ready;
    logic          Req1_Valid = 1'b0;
    logic [3:0]    Req1_Fun = '0;
    logic [DW-1:0] Req1_A = '0;
    logic [DW-1:0] Req1_B = '0;
    logic          Req1_Ready;
    logic          Rsp_Valid;
    logic          Rsp_Id;
    logic [DW-1:0] Rsp_Data;
    logic          Rsp_Ready = 1'b0;
    logic [3:0]    ALU_FUN;
    logic [DW-1:0] ALU_A;
    logic [DW-1:0] ALU_B;
    logic          ALU_EN;
    logic [DW-1:0] ALU_OUT;
    logic          Busy;

    alu_req_scheduler #(.DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST),
        .Req0_Valid(Req0_Valid), .Req0_Fun(Req0_Fun),
        .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Ready(Req0_Ready),
        .Req1_Valid(Req1_Valid), .Req1_Fun(Req1_Fun),
        .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Ready(Req1_Ready),
        .Rsp_Valid(Rsp_Valid), .Rsp_Id(Rsp_Id), .Rsp_Data(Rsp_Data),
        .Rsp_Ready(Rsp_Ready),
        .ALU_FUN(ALU_FUN), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_EN(ALU_EN), .ALU_OUT(ALU_OUT), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            id;
        logic [DW-1:0] data;
    } rsp_t;

    int            n_checks = 0;
    int            n_fail = 0;
    rsp_t          sb[$];
    int            m_en_left = 0;
    bit            m_pending = 1'b0;
    bit            m_last = 1'b1;
    logic [3:0]    m_fun = '0;
    logic [DW-1:0] m_a = '0;
    logic [DW-1:0] m_b = '0;
    int            en_run;
    logic [DW-1:0] junk = '0;

    function automatic int lat_of(input logic [3:0] f);
        case (f[3:2])
            2'b00:   return 2;
            2'b01:   return 1;
            2'b10:   return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [DW-1:0] alu_f(input logic [3:0] f,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (f[3:2])
            2'b00: return f[0] ? a - b : a + b;
            2'b01: begin
                case (f[1:0])
                    2'b00:   return a & b;
                    2'b01:   return a | b;
                    2'b10:   return a ^ b;
                    default: return ~a;
                endcase
            end
            2'b10:   return f[0] ? DW'(a == b) : DW'(a < b);
            default: return f[0] ? a >> b[3:0] : a << b[3:0];
        endcase
    endfunction

    // Shift results also carry the enable-cycle index, so the captured
    // value reveals which enable cycle was sampled.
    always @(posedge CLK or negedge RST) begin
        if (!RST) en_run <= 0;
        else en_run <= ALU_EN ? en_run + 1 : 0;
    end

    always_comb begin
        ALU_OUT = junk;
        if (ALU_EN) begin
            ALU_OUT = alu_f(ALU_FUN, ALU_A, ALU_B);
            if (ALU_FUN[3:2] == 2'b11) ALU_OUT = ALU_OUT ^ DW'(en_run);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd();
        return DW'($urandom);
    endfunction

    task automatic model_reset();
        m_en_left = 0;
        m_pending = 1'b0;
        m_last    = 1'b1;
        m_fun     = '0;
        m_a       = '0;
        m_b       = '0;
        sb.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rsp_valid"}, 32'(Rsp_Valid), 0);
        chk({tag, "_rsp_id"}, 32'(Rsp_Id), 0);
        chk({tag, "_rsp_data"}, 32'(Rsp_Data), 0);
        chk({tag, "_alu_fun"}, 32'(ALU_FUN), 0);
        chk({tag, "_alu_a"}, 32'(ALU_A), 0);
        chk({tag, "_alu_b"}, 32'(ALU_B), 0);
        chk({tag, "_alu_en"}, 32'(ALU_EN), 0);
        chk({tag, "_busy"}, 32'(Busy), 0);
        chk({tag, "_req0_ready"}, 32'(Req0_Ready), 0);
        chk({tag, "_req1_ready"}, 32'(Req1_Ready), 0);
    endtask

    // One clock cycle: drive, check control outputs, advance the model.
    task automatic step(input bit v0, input logic [3:0] f0,
                        input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                        input bit v1, input logic [3:0] f1,
                        input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                        input bit rr);
        bit            e_en;
        bit            e_rv;
        bit            e_r0;
        bit            e_r1;
        logic [DW-1:0] d;
        @(negedge CLK);
        Req0_Valid = v0; Req0_Fun = f0; Req0_A = a0; Req0_B = b0;
        Req1_Valid = v1; Req1_Fun = f1; Req1_A = a1; Req1_B = b1;
        Rsp_Ready  = rr;
        junk       = rd();
        #1;
        e_en = (m_en_left > 0);
        e_rv = m_pending && !e_en;
        e_r0 = !m_pending && v0 && (!v1 || m_last);
        e_r1 = !m_pending && v1 && (!v0 || !m_last);
        chk("req0_ready", 32'(Req0_Ready), 32'(e_r0));
        chk("req1_ready", 32'(Req1_Ready), 32'(e_r1));
        chk("alu_en", 32'(ALU_EN), 32'(e_en));
        chk("rsp_valid", 32'(Rsp_Valid), 32'(e_rv));
        chk("busy", 32'(Busy), 32'(m_pending));
        chk("alu_fun", 32'(ALU_FUN), 32'(m_fun));
        chk("alu_a", 32'(ALU_A), 32'(m_a));
        chk("alu_b", 32'(ALU_B), 32'(m_b));
        if (e_en) m_en_left--;
        else if (e_rv && rr) m_pending = 1'b0;
        if (e_r0 || e_r1) begin
            m_pending = 1'b1;
            m_last    = e_r1;
            m_fun     = e_r1 ? f1 : f0;
            m_a       = e_r1 ? a1 : a0;
            m_b       = e_r1 ? b1 : b0;
            m_en_left = lat_of(m_fun);
            d = alu_f(m_fun, m_a, m_b);
            if (m_fun[3:2] == 2'b11) d = d ^ DW'(m_en_left - 1);
            sb.push_back('{id: e_r1, data: d});
        end
    endtask

    task automatic idle(input int n, input bit rr);
        repeat (n) step(0, 4'(rd()), rd(), rd(), 0, 4'(rd()), rd(), rd(), rr);
    endtask

    // Response monitor: the front entry must be presented and held until taken.
    always @(negedge CLK) begin
        #2;
        if (RST && Rsp_Valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(Rsp_Valid), 0);
            end else begin
                chk("rsp_id", 32'(Rsp_Id), 32'(sb[0].id));
                chk("rsp_data", 32'(Rsp_Data), 32'(sb[0].data));
                if (Rsp_Ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        RST = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            Req0_Valid = 1'($urandom); Req0_Fun = 4'(rd());
            Req1_Valid = 1'($urandom); Req1_Fun = 4'(rd());
            Req0_A = rd(); Req1_A = rd(); Rsp_Ready = 1'($urandom);
            #1;
            chk_zero("reset");
        end
        @(negedge CLK);
        Req0_Valid = 1'b0; Req1_Valid = 1'b0; Rsp_Ready = 1'b0;
        RST = 1'b1;
        model_reset();

        // First contention after reset goes to requester 0.
        step(1, 4'b0100, rd(), rd(), 1, 4'b0100, rd(), rd(), 1);
        idle(4, 1);

        // Single arithmetic add: 5 + 3.
        step(1, 4'b0000, 16'd5, 16'd3, 0, 4'b0000, '0, '0, 1);
        idle(4, 1);

        // Continuous contention on logic ops alternates the winner.
        repeat (12) step(1, 4'b0100, rd(), rd(), 1, 4'b0100, rd(), rd(), 1);
        idle(3, 1);

        // Back-pressure while both keep requesting.
        step(1, 4'b0001, rd(), rd(), 0, 4'b0000, '0, '0, 0);
        repeat (7) step(1, 4'b0110, rd(), rd(), 1, 4'b1000, rd(), rd(), 0);
        step(1, 4'b0110, rd(), rd(), 1, 4'b1000, rd(), rd(), 1);
        step(1, 4'b0110, rd(), rd(), 1, 4'b1000, rd(), rd(), 1);
        idle(4, 1);

        // Shift class from requester 1.
        step(0, 4'b0000, '0, '0, 1, 4'b1101, rd(), rd(), 1);
        idle(5, 1);

        repeat (600) begin
            step(1'($urandom), 4'(rd()), rd(), rd(),
                 1'($urandom), 4'(rd()), rd(), rd(),
                 ($urandom_range(0, 3) != 0));
        end
        idle(8, 1);

        // Reset while the ALU is enabled.
        step(0, 4'b0000, '0, '0, 1, 4'b0000, rd(), rd(), 1);
        idle(1, 1);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk_zero("midreset");
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        idle(4, 1);
        step(1, 4'b1010, rd(), rd(), 1, 4'b0010, rd(), rd(), 1);
        idle(10, 1);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
